sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO; next generation of the team's FIFO family for same-domain buffering (packet staging ahead of the async FIFO, in-domain rate smoothing).
- Depth is a power of two set by ADDR_WIDTH.
- Adds occupancy count and programmable almost-full/almost-empty flags.
- Registered read data with one-cycle latency.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_mem.sv | 48 ++++
 rtl/sync_fifo_param.sv | 134 +++++++++++++
 tb/tb_sync_fifo_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: default geometry and the
// pointer compare used by both the synchronous and asynchronous FIFOs.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        PTR_NORMAL = 2'd0,
        PTR_EMPTY  = 2'd1,
        PTR_FULL   = 2'd2
    } ptr_cmp_e;

    // Pointers are addr_width+1 bits, zero-extended to 32; only the extra MSB
    // differing means the writer has lapped the reader exactly once.
    function automatic ptr_cmp_e ptr_compare(input logic [31:0] wr_ptr,
                                             input logic [31:0] rd_ptr,
                                             input int unsigned addr_width);
        logic [31:0] low_mask;
        logic [31:0] ptr_mask;
        logic [31:0] diff;
        low_mask = (32'd1 << addr_width) - 32'd1;
        ptr_mask = (low_mask << 1) | 32'd1;
        diff     = (wr_ptr ^ rd_ptr) & ptr_mask;
        if (diff == 32'd0) begin
            return PTR_EMPTY;
        end
        if (diff == (low_mask + 32'd1)) begin
            return PTR_FULL;
        end
        return PTR_NORMAL;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, synchronous registered read.
// The read register resets to zero; the array itself is never cleared.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count and almost flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky OVERFLOW/UNDERFLOW and ERR_CLR.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int          AF_THRESH  = 14,
    parameter int          AE_THRESH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                  ERR_CLR,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
`endif
);

    localparam int unsigned   DEPTH   = 32'd1 << ADDR_WIDTH;
    localparam int unsigned   PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > int'(DEPTH)) begin : g_af_range
        $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > int'(DEPTH) - 1) begin : g_ae_range
        $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [PW-1:0] count;
    ptr_cmp_e      ptr_state;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

    // Flags come only from registered pointers, so requests never reach outputs combinationally.
    always_comb begin
        ptr_state = ptr_compare(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH);
        full      = (ptr_state == PTR_FULL);
        empty     = (ptr_state == PTR_EMPTY);
        count     = wr_ptr_q - rd_ptr_q;
        wr_en     = W_INC && !full;
        rd_en     = R_INC && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (CLK),
        .rst_n(RST),
        .wen  (wr_en),
        .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata(WR_DATA),
        .ren  (rd_en),
        .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata(RD_DATA)
    );

    assign FULL         = full;
    assign EMPTY        = empty;
    assign COUNT        = count;
    assign ALMOST_FULL  = (count >= AF_LVL);
    assign ALMOST_EMPTY = (count <= AE_LVL);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_d, overflow_q;
    logic underflow_d, underflow_q;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (ERR_CLR) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (W_INC && full) begin
                overflow_d = 1'b1;
            end
            if (R_INC && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default geometry
// (8-bit data, 16 deep, AF=14, AE=2); honours SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_param;

    logic       CLK;
    logic       RST;
    logic       W_INC;
    logic [7:0] WR_DATA;
    logic       R_INC;
    logic [7:0] RD_DATA;
    logic       FULL;
    logic       EMPTY;
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;
    logic [4:0] COUNT;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       ERR_CLR;
    logic       OVERFLOW;
    logic       UNDERFLOW;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_INC       (W_INC),
        .WR_DATA     (WR_DATA),
        .R_INC       (R_INC),
        .RD_DATA     (RD_DATA),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .ALMOST_FULL (ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY),
        .COUNT       (COUNT)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .ERR_CLR     (ERR_CLR),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and sampled at the next one.
    task automatic tick(input logic w, input logic [7:0] d, input logic r);
        W_INC   = w;
        WR_DATA = d;
        R_INC   = r;
        @(posedge CLK);
        #1;
        W_INC   = 1'b0;
        R_INC   = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] q[$];
        logic [7:0] exp_rd;
        int         nw;
        int         nr;
        int         cyc;
        int         max_cnt;
        int         full_seen;
        logic       w;
        logic       r;
        logic       wa;
        logic       ra;

        RST     = 1'b0;
        W_INC   = 1'b0;
        R_INC   = 1'b0;
        WR_DATA = 8'h00;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ERR_CLR = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_ae", 32'(ALMOST_EMPTY), 32'd1);
        check("rst_af", 32'(ALMOST_FULL), 32'd0);
        check("rst_rd", 32'(RD_DATA), 32'h00);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        check("rst_udf", 32'(UNDERFLOW), 32'd0);
`endif
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Mid-stream reset after 5 writes and one read.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h11 + i), 1'b0);
        check("mid_count5", 32'(COUNT), 32'd5);
        tick(1'b0, 8'h00, 1'b1);
        check("mid_rd", 32'(RD_DATA), 32'h11);
        check("mid_count4", 32'(COUNT), 32'd4);
        #2;
        RST = 1'b0;
        #1;
        check("arst_count", 32'(COUNT), 32'd0);
        check("arst_empty", 32'(EMPTY), 32'd1);
        check("arst_ae", 32'(ALMOST_EMPTY), 32'd1);
        check("arst_rd", 32'(RD_DATA), 32'h00);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        tick(1'b1, 8'hA5, 1'b0);
        check("post_rst_count", 32'(COUNT), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        check("post_rst_rd", 32'(RD_DATA), 32'hA5);
        check("post_rst_empty", 32'(EMPTY), 32'd1);

        // Fill 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            check("fill_count", 32'(COUNT), 32'(i + 1));
            check("fill_af", 32'(ALMOST_FULL), 32'((i + 1) >= 14));
            check("fill_full", 32'(FULL), 32'((i + 1) == 16));
            check("fill_ae", 32'(ALMOST_EMPTY), 32'((i + 1) <= 2));
            check("fill_empty", 32'(EMPTY), 32'd0);
        end
        tick(1'b1, 8'hFF, 1'b0);
        check("ovf_count", 32'(COUNT), 32'd16);
        check("ovf_full", 32'(FULL), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(OVERFLOW), 32'd1);
        check("ovf_udf_clear", 32'(UNDERFLOW), 32'd0);
`endif

        // Drain expecting 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            check("drain_rd", 32'(RD_DATA), 32'(i));
            check("drain_count", 32'(COUNT), 32'(15 - i));
            check("drain_ae", 32'(ALMOST_EMPTY), 32'((15 - i) <= 2));
            check("drain_empty", 32'(EMPTY), 32'((15 - i) == 0));
            check("drain_full", 32'(FULL), 32'd0);
        end
        tick(1'b0, 8'h00, 1'b1);
        check("udf_rd_hold", 32'(RD_DATA), 32'h0F);
        check("udf_count", 32'(COUNT), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("udf_flag", 32'(UNDERFLOW), 32'd1);
        ERR_CLR = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        ERR_CLR = 1'b0;
        check("errclr_udf", 32'(UNDERFLOW), 32'd0);
        check("errclr_ovf", 32'(OVERFLOW), 32'd0);
`endif

        // Simultaneous read/write at COUNT=8.
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h20 + i), 1'b0);
        check("sim_pre_count", 32'(COUNT), 32'd8);
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 8'(8'h28 + k), 1'b1);
            check("sim_rd", 32'(RD_DATA), 32'(8'h20 + k));
            check("sim_count", 32'(COUNT), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            check("sim_tail_rd", 32'(RD_DATA), 32'(8'h34 + i));
        end
        check("sim_tail_empty", 32'(EMPTY), 32'd1);

        // Both requests while FULL: read wins, write dropped.
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h40 + i), 1'b0);
        check("both_full_pre", 32'(FULL), 32'd1);
        tick(1'b1, 8'hEE, 1'b1);
        check("both_full_count", 32'(COUNT), 32'd15);
        check("both_full_rd", 32'(RD_DATA), 32'h40);
        check("both_full_flag", 32'(FULL), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 8'h00, 1'b1);
            check("both_full_drain", 32'(RD_DATA), 32'(8'h41 + i));
        end
        check("both_full_empty", 32'(EMPTY), 32'd1);

        // Both requests while EMPTY: write lands, read ignored, no bypass.
        tick(1'b1, 8'h77, 1'b1);
        check("both_empty_count", 32'(COUNT), 32'd1);
        check("both_empty_rd", 32'(RD_DATA), 32'h4F);
        check("both_empty_flag", 32'(EMPTY), 32'd0);
        tick(1'b0, 8'h00, 1'b1);
        check("both_empty_next", 32'(RD_DATA), 32'h77);
        check("both_empty_after", 32'(EMPTY), 32'd1);

        // Random interleave against a queue model.
        q.delete();
        nw  = 0;
        nr  = 0;
        cyc = 0;
        while (nr < 100 && cyc < 2000) begin
            w  = (nw < 100) && ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 2) != 0);
            wa = w && (q.size() < 16);
            ra = r && (q.size() > 0);
            exp_rd = 8'h00;
            if (ra) exp_rd = q.pop_front();
            if (wa) begin
                q.push_back(8'(8'h80 + nw));
                nw++;
            end
            tick(w, 8'(8'h80 + nw - (wa ? 1 : 0)), r);
            if (ra) begin
                check("wrap_rd", 32'(RD_DATA), 32'(exp_rd));
                nr++;
            end
            check("wrap_count", 32'(COUNT), 32'(q.size()));
            cyc++;
        end
        check("wrap_reads_done", 32'(nr), 32'd100);

        // Packet burst: 10 writes, a read every third cycle.
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1);
        nr        = 0;
        max_cnt   = 0;
        full_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick(k < 10, 8'(8'hC0 + k), (k % 3) == 2);
            if ((k % 3) == 2) begin
                check("pkt_rd", 32'(RD_DATA), 32'(8'hC0 + nr));
                nr++;
            end
            if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
            if (FULL) full_seen = 1;
        end
        check("pkt_max_count", 32'(max_cnt), 32'd7);
        check("pkt_full_seen", 32'(full_seen), 32'd0);
        check("pkt_empty", 32'(EMPTY), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
